bp_resolve_unit: RTL and testbench

- Execute-side counterpart of the branch predictor's fetch interface.
- Records each prediction that fetch issues (PC, predicted target and direction, meta) in an in-order FIFO.
- Compares the oldest record against the resolved outcome from the ALU.
- Drives the predictor's execute_bpredictor_* update port and the fetch_redirect / fetch_redirect_PC recovery path.
- Sits between the fetch stage, the branch ALU and the predictor in the DE3 bpred harness.

---
 rtl/bp_resolve_unit.sv | 188 ++++++++++++++++++
 tb/tb_bp_resolve_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_unit.sv
// bp_resolve_unit
// Execute-side partner of the branch predictor. Fetch pushes every prediction
// it makes into an in-order record FIFO; when the ALU resolves the oldest
// branch, the head record is compared against the real outcome. That result
// drives the predictor update port and, on a misprediction, the fetch
// redirect path.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   fetch_resolve_*                 prediction record push from fetch
//   resolve_fetch_ready             FIFO can accept a push (state decode)
//   alu_resolve_*                   resolved outcome of the oldest branch
//   execute_bpredictor_*            registered predictor update port
//   fetch_redirect, _PC             registered redirect pulse and target
//   resolve_count                   record occupancy 0..DEPTH
//   resolve_error                   sticky overflow/underflow flag
module bp_resolve_unit #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned META_WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_resolve_valid,
    input  logic [31:0]                  fetch_resolve_PC,
    input  logic [31:0]                  fetch_resolve_p_target,
    input  logic                         fetch_resolve_p_dir,
    input  logic [META_WIDTH-1:0]        fetch_resolve_meta,
    output logic                         resolve_fetch_ready,
    input  logic                         alu_resolve_valid,
    input  logic [31:0]                  alu_resolve_target,
    input  logic                         alu_resolve_dir,
    output logic                         execute_bpredictor_update,
    output logic [31:0]                  execute_bpredictor_PC,
    output logic [31:0]                  execute_bpredictor_target,
    output logic                         execute_bpredictor_dir,
    output logic                         execute_bpredictor_miss,
    output logic [31:0]                  execute_bpredictor_meta,
    output logic                         execute_bpredictor_recover_ras,
    output logic                         fetch_redirect,
    output logic [31:0]                  fetch_redirect_PC,
    output logic [$clog2(DEPTH):0]       resolve_count,
    output logic                         resolve_error
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0]           pc_mem   [DEPTH];
    logic [31:0]           tgt_mem  [DEPTH];
    logic                  dir_mem  [DEPTH];
    logic [META_WIDTH-1:0] meta_mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          ready_c;
    logic          pop_c;
    logic          do_push_c;
    logic          flush_c;
    logic          mismatch_c;
    logic          err_set_c;
    logic [31:0]   head_pc_c;
    logic [31:0]   head_tgt_c;
    logic          head_dir_c;
    logic [31:0]   actual_next_c;
    logic [31:0]   pred_next_c;

    // Occupancy / control decode
    always_comb begin
        ready_c       = (state_q == RUN) && (count_q < CW'(DEPTH));
        head_pc_c     = pc_mem[rd_ptr_q];
        head_tgt_c    = tgt_mem[rd_ptr_q];
        head_dir_c    = dir_mem[rd_ptr_q];
        actual_next_c = alu_resolve_dir ? alu_resolve_target : head_pc_c + 32'd4;
        pred_next_c   = head_dir_c ? head_tgt_c : head_pc_c + 32'd4;
        mismatch_c    = (actual_next_c != pred_next_c);
        pop_c         = alu_resolve_valid && (state_q == RUN) && (count_q != '0);
        flush_c       = pop_c && mismatch_c;
        // A push alongside a mispredicting resolve is wrong-path and is dropped
        do_push_c     = fetch_resolve_valid && ready_c && !flush_c;
        // RECOVER drops pushes/resolves silently; only RUN flags misuse
        err_set_c     = (state_q == RUN) &&
                        ((fetch_resolve_valid && (count_q == CW'(DEPTH))) ||
                         (alu_resolve_valid && (count_q == '0)));
    end

    assign resolve_fetch_ready = ready_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_c) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    logic upd_d, miss_d, redirect_d;

    // Output strobe decode, registered below
    always_comb begin
        upd_d      = 1'b0;
        miss_d     = 1'b0;
        redirect_d = 1'b0;
        if (state_q == RUN) begin
            upd_d      = pop_c;
            miss_d     = flush_c;
            redirect_d = flush_c;
        end
    end

    // Record storage; no reset needed, occupancy qualifies every read
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            pc_mem[wr_ptr_q]   <= fetch_resolve_PC;
            tgt_mem[wr_ptr_q]  <= fetch_resolve_p_target;
            dir_mem[wr_ptr_q]  <= fetch_resolve_p_dir;
            meta_mem[wr_ptr_q] <= fetch_resolve_meta;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_c) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            case ({do_push_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign resolve_count = count_q;

    // Registered update / redirect outputs; data fields hold between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            execute_bpredictor_update      <= 1'b0;
            execute_bpredictor_PC          <= '0;
            execute_bpredictor_target      <= '0;
            execute_bpredictor_dir         <= 1'b0;
            execute_bpredictor_miss        <= 1'b0;
            execute_bpredictor_meta        <= '0;
            execute_bpredictor_recover_ras <= 1'b0;
            fetch_redirect                 <= 1'b0;
            fetch_redirect_PC              <= '0;
            resolve_error                  <= 1'b0;
        end else begin
            execute_bpredictor_update      <= upd_d;
            execute_bpredictor_miss        <= miss_d;
            execute_bpredictor_recover_ras <= miss_d;
            fetch_redirect                 <= redirect_d;
            if (upd_d) begin
                execute_bpredictor_PC     <= head_pc_c;
                execute_bpredictor_target <= alu_resolve_target;
                execute_bpredictor_dir    <= alu_resolve_dir;
                execute_bpredictor_meta   <= 32'(meta_mem[rd_ptr_q]);
            end
            if (redirect_d) fetch_redirect_PC <= actual_next_c;
            if (err_set_c)  resolve_error     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Self-checking bench for bp_resolve_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_bp_resolve_unit;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned MW    = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_resolve_valid;
    logic [31:0] fetch_resolve_PC;
    logic [31:0] fetch_resolve_p_target;
    logic        fetch_resolve_p_dir;
    logic [MW-1:0] fetch_resolve_meta;
    logic        resolve_fetch_ready;
    logic        alu_resolve_valid;
    logic [31:0] alu_resolve_target;
    logic        alu_resolve_dir;
    logic        execute_bpredictor_update;
    logic [31:0] execute_bpredictor_PC;
    logic [31:0] execute_bpredictor_target;
    logic        execute_bpredictor_dir;
    logic        execute_bpredictor_miss;
    logic [31:0] execute_bpredictor_meta;
    logic        execute_bpredictor_recover_ras;
    logic        fetch_redirect;
    logic [31:0] fetch_redirect_PC;
    logic [3:0]  resolve_count;
    logic        resolve_error;

    bp_resolve_unit #(.DEPTH(DEPTH), .META_WIDTH(MW)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .fetch_resolve_valid            (fetch_resolve_valid),
        .fetch_resolve_PC               (fetch_resolve_PC),
        .fetch_resolve_p_target         (fetch_resolve_p_target),
        .fetch_resolve_p_dir            (fetch_resolve_p_dir),
        .fetch_resolve_meta             (fetch_resolve_meta),
        .resolve_fetch_ready            (resolve_fetch_ready),
        .alu_resolve_valid              (alu_resolve_valid),
        .alu_resolve_target             (alu_resolve_target),
        .alu_resolve_dir                (alu_resolve_dir),
        .execute_bpredictor_update      (execute_bpredictor_update),
        .execute_bpredictor_PC          (execute_bpredictor_PC),
        .execute_bpredictor_target      (execute_bpredictor_target),
        .execute_bpredictor_dir         (execute_bpredictor_dir),
        .execute_bpredictor_miss        (execute_bpredictor_miss),
        .execute_bpredictor_meta        (execute_bpredictor_meta),
        .execute_bpredictor_recover_ras (execute_bpredictor_recover_ras),
        .fetch_redirect                 (fetch_redirect),
        .fetch_redirect_PC              (fetch_redirect_PC),
        .resolve_count                  (resolve_count),
        .resolve_error                  (resolve_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of outstanding predictions
    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   tgt;
        logic          dir;
        logic [MW-1:0] meta;
    } rec_t;

    rec_t        q[$];
    bit          m_known = 0;
    bit          m_recover = 0;
    bit          e_update, e_dir, e_miss, e_redirect, e_error;
    logic [31:0] e_pc, e_target, e_meta, e_redirect_pc;

    // Apply one cycle of inputs, advance the model, check every output
    task automatic cycle(input bit rst, input bit fv, input logic [31:0] fpc,
                         input logic [31:0] ftgt, input bit fdir, input logic [MW-1:0] fmeta,
                         input bit av, input logic [31:0] atgt, input bit adir);
        bit   exp_ready, flushed;
        rec_t h, n;
        logic [31:0] act, prd;
        reset                  = rst;
        fetch_resolve_valid    = fv;
        fetch_resolve_PC       = fpc;
        fetch_resolve_p_target = ftgt;
        fetch_resolve_p_dir    = fdir;
        fetch_resolve_meta     = fmeta;
        alu_resolve_valid      = av;
        alu_resolve_target     = atgt;
        alu_resolve_dir        = adir;
        exp_ready = !m_recover && (q.size() < DEPTH);
        if (m_known) check("ready", 32'(resolve_fetch_ready), 32'(exp_ready));

        e_update = 0; e_miss = 0; e_redirect = 0;
        if (rst) begin
            q.delete();
            m_recover = 0; m_known = 1;
            e_dir = 0; e_error = 0;
            e_pc = 0; e_target = 0; e_meta = 0; e_redirect_pc = 0;
        end else if (m_recover) begin
            m_recover = 0;
        end else begin
            flushed = 0;
            if (fv && q.size() == DEPTH) e_error = 1;
            if (av) begin
                if (q.size() == 0) e_error = 1;
                else begin
                    h   = q.pop_front();
                    act = adir ? atgt : h.pc + 32'd4;
                    prd = h.dir ? h.tgt : h.pc + 32'd4;
                    e_update = 1;
                    e_pc = h.pc; e_target = atgt; e_dir = adir; e_meta = 32'(h.meta);
                    if (act != prd) begin
                        e_miss = 1; e_redirect = 1; e_redirect_pc = act;
                        q.delete(); flushed = 1; m_recover = 1;
                    end
                end
            end
            if (fv && exp_ready && !flushed) begin
                n.pc = fpc; n.tgt = ftgt; n.dir = fdir; n.meta = fmeta;
                q.push_back(n);
            end
        end

        @(posedge clk); #1;
        check("update",     32'(execute_bpredictor_update), 32'(e_update));
        check("pc",         execute_bpredictor_PC, e_pc);
        check("target",     execute_bpredictor_target, e_target);
        check("dir",        32'(execute_bpredictor_dir), 32'(e_dir));
        check("miss",       32'(execute_bpredictor_miss), 32'(e_miss));
        check("meta",       execute_bpredictor_meta, e_meta);
        check("ras",        32'(execute_bpredictor_recover_ras), 32'(e_miss));
        check("redirect",   32'(fetch_redirect), 32'(e_redirect));
        check("redirect_pc", fetch_redirect_PC, e_redirect_pc);
        check("count",      32'(resolve_count), 32'(q.size()));
        check("error",      32'(resolve_error), 32'(e_error));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input bit d, input logic [MW-1:0] m);
        cycle(0, 1, pc, tgt, d, m, 0, 0, 0);
    endtask
    task automatic resolve(input logic [31:0] tgt, input bit d);
        cycle(0, 0, 0, 0, 0, 0, 1, tgt, d);
    endtask

    initial begin
        // Reset held two cycles
        do_reset();
        do_reset();
        check("rst_ready", 32'(resolve_fetch_ready), 32'd1);
        check("rst_count", 32'(resolve_count), 32'd0);

        // Correct prediction
        push(32'h100, 32'h200, 1, 24'hABCDEF);
        resolve(32'h200, 1);
        check("hit_meta", execute_bpredictor_meta, 32'h00ABCDEF);
        check("hit_miss", 32'(execute_bpredictor_miss), 32'd0);

        // Not-taken predicted, taken actual
        push(32'h104, 32'h0, 0, 24'h1);
        resolve(32'h300, 1);
        check("mis_rpc", fetch_redirect_PC, 32'h300);
        check("mis_ready_rec", 32'(resolve_fetch_ready), 32'd0);
        idle();
        check("mis_ready_run", 32'(resolve_fetch_ready), 32'd1);

        // Taken predicted, not-taken actual, with a wrong-path push
        push(32'h120, 32'h180, 1, 24'h2);
        push(32'h124, 32'h0, 0, 24'h3);
        cycle(0, 1, 32'h128, 32'h0, 0, 24'h4, 1, 32'h0, 0);
        check("nt_rpc", fetch_redirect_PC, 32'h124);
        check("nt_count", 32'(resolve_count), 32'd0);
        idle();

        // Fill, overflow, oldest-first pop
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(4 * i), 32'h0, 0, MW'(i));
        check("full_count", 32'(resolve_count), 32'd8);
        push(32'h500, 32'h0, 0, 24'h9);
        check("ovf_error", 32'(resolve_error), 32'd1);
        resolve(32'h0, 0);
        check("ovf_head", execute_bpredictor_PC, 32'h100);

        // Underflow
        do_reset();
        resolve(32'h0, 1);
        check("udf_error", 32'(resolve_error), 32'd1);

        // Reset during RECOVER
        push(32'h40, 32'h80, 1, 24'h5);
        resolve(32'h0, 0);
        do_reset();
        check("rr_update", 32'(execute_bpredictor_update), 32'd0);
        check("rr_error", 32'(resolve_error), 32'd0);

        // Random traffic over a small address/target set to mix hits and misses
        for (int c = 0; c < 3000; c++) begin
            bit rst = ($urandom_range(0, 249) == 0);
            bit fv  = ($urandom_range(0, 99) < 60);
            bit av  = ($urandom_range(0, 99) < 40);
            cycle(rst, fv, 32'h1000 + 32'($urandom_range(0, 15) * 4),
                  32'h2000 + 32'($urandom_range(0, 1) * 16), 1'($urandom_range(0, 1)),
                  MW'($urandom), av, 32'h2000 + 32'($urandom_range(0, 1) * 16),
                  1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
